// File: rtl/block_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_window_gen_pkg
// Description : Shared definitions for the neighbourhood block generator:
//               background pad default, block bit positions, FSM encodings
//               and the block packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package block_window_gen_pkg;

  // Value substituted for pixels that fall outside the image (background)
  localparam logic PAD_DEFAULT = 1'b1;

  // Block layout: upper row in [5:3], current row in [2:0], each {c-2,c-1,c}
  localparam int BLOCK_W = 6;
  localparam int UP_L    = 5;
  localparam int UP_M    = 4;
  localparam int UP_R    = 3;
  localparam int CUR_L   = 2;
  localparam int CUR_M   = 1;
  localparam int CUR_R   = 0;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Assemble a block from the two-deep histories and the column-c pixels.
  // History bit [1] is column c-2, bit [0] is column c-1.
  function automatic logic [BLOCK_W-1:0] pack_block(
    input logic [1:0] up_hist,
    input logic       up_pix,
    input logic [1:0] cur_hist,
    input logic       cur_pix
  );
    logic [BLOCK_W-1:0] blk;
    blk        = '0;
    blk[UP_L]  = up_hist[1];
    blk[UP_M]  = up_hist[0];
    blk[UP_R]  = up_pix;
    blk[CUR_L] = cur_hist[1];
    blk[CUR_M] = cur_hist[0];
    blk[CUR_R] = cur_pix;
    return blk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_window_gen_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : block_window_gen_line_buf
// Description : One-line pixel store holding the previous row. Combinational
//               read, write on the rising edge when i_we is set. No reset:
//               every location is written before it is read within a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module block_window_gen_line_buf #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wdata,
  output logic              o_rdata
);

  logic mem_q [DEPTH];

  // Read-before-write: the old value is visible during the write cycle
  assign o_rdata = mem_q[i_addr];

  // Store the current pixel at its column for use by the next row
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/block_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : block_window_gen
// Description : Converts a raster binary pixel stream into one 6-bit
//               neighbourhood block per accepted pixel (upper and current
//               row, columns c-2..c), with position and end-of-line/frame
//               flags, one cycle after the pixel is accepted.
//               Optional feature macro BLOCK_FRAME_ERR_EN adds o_frame_err,
//               a one-cycle pulse on an aborted frame or a pixel dropped
//               after the frame completed.
// Revision    : 1.0 - initial release
// ============================================================================
module block_window_gen
  import block_window_gen_pkg::*;
#(
  parameter int   IMG_WIDTH  = 640,
  parameter int   IMG_HEIGHT = 480,
  parameter int   COL_W      = 10,
  parameter int   ROW_W      = 9,
  parameter logic PAD_VAL    = PAD_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sof,
  input  logic               i_pix_valid,
  input  logic               i_pix,
  output logic [BLOCK_W-1:0] o_block,
  output logic               o_block_vld,
  output logic [COL_W-1:0]   o_col,
  output logic [ROW_W-1:0]   o_row,
  output logic               o_eol,
  output logic               o_eof
`ifdef BLOCK_FRAME_ERR_EN
  ,
  output logic               o_frame_err
`endif
);

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [1:0]         up_sr_q, up_sr_d;
  logic [1:0]         cur_sr_q, cur_sr_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               vld_q, vld_d;
  logic [COL_W-1:0]   ocol_q, ocol_d;
  logic [ROW_W-1:0]   orow_q, orow_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;

  logic               w_start;
  logic               w_accept;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;
  logic               w_lb_rdata;
  logic               w_up;
  logic               w_last_col;
  logic               w_last_row;
  logic [1:0]         w_up_hist;
  logic [1:0]         w_cur_hist;

  // A sof pixel restarts at (0,0) from any state; otherwise only ACTIVE accepts
  assign w_start    = i_pix_valid & i_sof;
  assign w_accept   = i_pix_valid & (i_sof | (state_q == ST_ACTIVE));
  assign w_col      = w_start ? '0 : col_q;
  assign w_row      = w_start ? '0 : row_q;
  assign w_last_col = (w_col == c_COL_LAST);
  assign w_last_row = (w_row == c_ROW_LAST);

  // Row 0 has no row above; the stale line buffer contents are masked
  assign w_up       = (w_row == '0) ? PAD_VAL : w_lb_rdata;

  // Column 0 sees padding for c-1 and c-2 regardless of the previous line's tail
  assign w_up_hist  = (w_col == '0) ? {PAD_VAL, PAD_VAL} : up_sr_q;
  assign w_cur_hist = (w_col == '0) ? {PAD_VAL, PAD_VAL} : cur_sr_q;

  block_window_gen_line_buf #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (i_pix),
    .o_rdata (w_lb_rdata)
  );

  // Frame sequencing: enter ACTIVE on sof, DONE after the final pixel
  always_comb begin
    state_d = state_q;
    if (w_start) begin
      state_d = ST_ACTIVE;
    end else if (w_accept && w_last_col && w_last_row) begin
      state_d = ST_DONE;
    end
  end

  // Position counters, shift histories and the registered block outputs
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    up_sr_d  = up_sr_q;
    cur_sr_d = cur_sr_q;
    block_d  = block_q;
    ocol_d   = ocol_q;
    orow_d   = orow_q;
    vld_d    = 1'b0;
    eol_d    = 1'b0;
    eof_d    = 1'b0;
    if (w_accept) begin
      block_d  = pack_block(w_up_hist, w_up, w_cur_hist, i_pix);
      vld_d    = 1'b1;
      ocol_d   = w_col;
      orow_d   = w_row;
      eol_d    = w_last_col;
      eof_d    = w_last_col & w_last_row;
      up_sr_d  = {w_up_hist[0], w_up};
      cur_sr_d = {w_cur_hist[0], i_pix};
      if (w_last_col) begin
        col_d = '0;
        row_d = w_last_row ? '0 : (w_row + ROW_W'(1));
      end else begin
        col_d = w_col + COL_W'(1);
        row_d = w_row;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      up_sr_q  <= {PAD_VAL, PAD_VAL};
      cur_sr_q <= {PAD_VAL, PAD_VAL};
      block_q  <= '0;
      vld_q    <= 1'b0;
      ocol_q   <= '0;
      orow_q   <= '0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      up_sr_q  <= up_sr_d;
      cur_sr_q <= cur_sr_d;
      block_q  <= block_d;
      vld_q    <= vld_d;
      ocol_q   <= ocol_d;
      orow_q   <= orow_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
    end
  end

  assign o_block     = block_q;
  assign o_block_vld = vld_q;
  assign o_col       = ocol_q;
  assign o_row       = orow_q;
  assign o_eol       = eol_q;
  assign o_eof       = eof_q;

`ifdef BLOCK_FRAME_ERR_EN
  logic err_q, err_d;

  // Flag an abandoned frame or a stray pixel after the frame has completed
  always_comb begin
    err_d = (w_start && (state_q == ST_ACTIVE)) ||
            (i_pix_valid && !i_sof && (state_q == ST_DONE));
  end

  // Error pulse register, aligned with the block output timing
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_frame_err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_window_gen
// Description : Randomised scoreboard bench for block_window_gen on a 4x3
//               image, with a frame-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_window_gen;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam bit PAD = 1'b1;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DONE   = 2;

  logic       clk;
  logic       rst;
  logic       i_sof;
  logic       i_pix_valid;
  logic       i_pix;
  logic [5:0] o_block;
  logic       o_block_vld;
  logic [1:0] o_col;
  logic [1:0] o_row;
  logic       o_eol;
  logic       o_eof;
`ifdef BLOCK_FRAME_ERR_EN
  logic       o_frame_err;
`endif

  block_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COL_W      (2),
    .ROW_W      (2),
    .PAD_VAL    (PAD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sof       (i_sof),
    .i_pix_valid (i_pix_valid),
    .i_pix       (i_pix),
    .o_block     (o_block),
    .o_block_vld (o_block_vld),
    .o_col       (o_col),
    .o_row       (o_row),
    .o_eol       (o_eol),
    .o_eof       (o_eof)
`ifdef BLOCK_FRAME_ERR_EN
    ,
    .o_frame_err (o_frame_err)
`endif
  );

  typedef struct {
    logic [5:0] blk;
    int         col;
    int         row;
    logic       eol;
    logic       eof;
    int         due;
  } exp_t;

  exp_t q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state: the pixels of the current frame by position
  bit   frame [H][W];
  int   m_state = M_IDLE;
  int   m_r = 0;
  int   m_c = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit px(input int r, input int c);
    if (r < 0 || c < 0) return PAD;
    return frame[r][c];
  endfunction

  // Drive one cycle of input and advance the model
  task automatic drive(input bit v, input bit s, input bit p);
    exp_t e;
    @(negedge clk);
    i_pix_valid = v;
    i_sof       = s;
    i_pix       = p;
    if (v && s) begin
      if (m_state == M_ACTIVE) err_q.push_back(cyc + 1);
      m_state = M_ACTIVE;
      m_r = 0;
      m_c = 0;
    end else if (v && m_state == M_DONE) begin
      err_q.push_back(cyc + 1);
    end
    if (v && m_state == M_ACTIVE) begin
      frame[m_r][m_c] = p;
      e.blk = {px(m_r - 1, m_c - 2), px(m_r - 1, m_c - 1), px(m_r - 1, m_c),
               px(m_r, m_c - 2), px(m_r, m_c - 1), p};
      e.col = m_c;
      e.row = m_r;
      e.eol = (m_c == W - 1);
      e.eof = (m_c == W - 1) && (m_r == H - 1);
      e.due = cyc + 1;
      q.push_back(e);
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r++;
        if (m_r == H) begin
          m_r = 0;
          m_state = M_DONE;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Full frame of value val with one inverted pixel at (zr,zc); gap_pct chance of gaps
  task automatic frame_run(input bit val, input int zr, input int zc, input int gap_pct, input bit rnd);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        bit p;
        p = rnd ? 1'($urandom_range(0, 1)) : ((r == zr && c == zc) ? ~val : val);
        drive(1'b1, (r == 0 && c == 0), p);
        if (int'($urandom_range(0, 99)) < gap_pct) idle($urandom_range(1, 5));
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (o_block_vld !== 1'b0 || o_block !== 6'd0 || o_col !== 2'd0 ||
        o_row !== 2'd0 || o_eol !== 1'b0 || o_eof !== 1'b0) begin
      errors++;
      $display("FAIL %s: vld=%b blk=%b col=%0d row=%0d eol=%b eof=%b, required all 0",
               name, o_block_vld, o_block, o_col, o_row, o_eol, o_eof);
    end
  endtask

  // Monitor: compare every presented block against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_block_vld === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld: blk=%b col=%0d row=%0d at cycle %0d, required no output",
                   o_block, o_col, o_row, cyc);
        end else begin
          e = q.pop_front();
          if (o_block !== e.blk || int'(o_col) != e.col || int'(o_row) != e.row ||
              o_eol !== e.eol || o_eof !== e.eof || cyc != e.due) begin
            errors++;
            $display("FAIL block: got blk=%b col=%0d row=%0d eol=%b eof=%b cyc=%0d, required blk=%b col=%0d row=%0d eol=%b eof=%b cyc=%0d",
                     o_block, o_col, o_row, o_eol, o_eof, cyc,
                     e.blk, e.col, e.row, e.eol, e.eof, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missing_vld: vld=%b at cycle %0d, required block %b for (%0d,%0d)",
                 o_block_vld, cyc, e.blk, e.row, e.col);
      end
      if (o_block_vld !== 1'b1 && (o_eol !== 1'b0 || o_eof !== 1'b0)) begin
        checks++;
        errors++;
        $display("FAIL flags_without_vld: eol=%b eof=%b, required 0", o_eol, o_eof);
      end
`ifdef BLOCK_FRAME_ERR_EN
      begin
        bit exp_err;
        exp_err = (err_q.size() > 0 && err_q[0] == cyc);
        if (exp_err) void'(err_q.pop_front());
        checks++;
        if (o_frame_err !== exp_err) begin
          errors++;
          $display("FAIL frame_err: got %b at cycle %0d, required %b", o_frame_err, cyc, exp_err);
        end
      end
`endif
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    i_sof       = 1'b0;
    i_pix_valid = 1'b0;
    i_pix       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Pixels in IDLE without sof are dropped
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // All-zero frame, then all-ones frame with a single 0 at (1,2) and gaps
    frame_run(1'b0, -1, -1, 0, 1'b0);
    frame_run(1'b1, 1, 2, 40, 1'b0);

    // Stray pixels after end of frame are dropped
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    idle(2);

    // Abort at (1,1) with sof, then a full frame
    for (int i = 0; i < W + 1; i++) drive(1'b1, (i == 0), 1'b0);
    frame_run(1'b0, 0, 0, 20, 1'b1);

    // Random frames with gaps (including 5-cycle gaps mid-line)
    for (int f = 0; f < 6; f++) frame_run(1'b0, 0, 0, 30, 1'b1);

    // Unconstrained traffic with occasional sof
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a line
    for (int i = 0; i < W + 2; i++) drive(1'b1, (i == 0), 1'($urandom_range(0, 1)));
    @(posedge clk);
    #3;
    rst         = 1'b1;
    i_pix_valid = 1'b0;
    #1;
    check_zero("async_reset");
    q.delete();
    err_q.delete();
    m_state = M_IDLE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    frame_run(1'b0, 0, 0, 20, 1'b1);

    idle(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d blocks outstanding, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
